pattern_sequencer: RTL and testbench
====================================

# pattern_sequencer

Parametrised pattern sequencer: a synchronous prescaler generates a step tick, and a step counter walks a writable pattern table to drive a WIDTH-bit output. It has forward, reverse, ping-pong and hold modes and a sequence-done pulse. It replaces the fixed 8-step, ripple-divided light-pattern generator and sits directly behind the chip I/O wrapper. All logic runs on one clock; division uses clock enables only, with no derived clocks.

## Interface
- WIDTH, 8: output pattern width.
- DEPTH, 8: number of steps in the pattern table; must be ≥2. SW = $clog2(DEPTH).
- DIV_BASE, 2: base prescale exponent. Tick period = 2^(DIV_BASE + 2·div_sel) cycles.

- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- div_sel  in  2  prescale select.
- mode  in  2  0 = forward, 1 = reverse, 2 = ping-pong, 3 = hold.
- wr_en  in  1  pattern table write strobe.
- wr_addr  in  SW  table index to write; ignored if ≥ DEPTH.
- wr_data  in  WIDTH  table write data.
- pattern_out  out  WIDTH  table[step], read combinationally from the flop array.
- step  out  SW  current step index.
- tick  out  1  one-cycle prescaler pulse.
- seq_done  out  1  one-cycle pulse at sequence end.
- half_rate  out  1  toggles on every seq_done.

## Operation
- Reset values:
  - prescaler count = 0; step = 0; dir = up.
  - tick = 0, seq_done = 0, half_rate = 0.
  - table[i] = 1 << (i mod WIDTH). pattern_out therefore resets to 1.
  - registered div_sel copy = 0.
- Prescaler: counter of DIV_BASE+6 bits, increments every cycle.
  - tick is asserted the cycle the low DIV_BASE+2·div_sel bits are all ones.
  - When div_sel differs from its registered copy, the counter clears to 0 and no tick is issued that cycle. The first tick after the change comes exactly one new period later.
- Step update happens only on a tick cycle, using the mode sampled in that cycle:
  - Forward: step+1, wrapping DEPTH-1→0. seq_done on the wrap. dir forced up.
  - Reverse: step−1, wrapping 0→DEPTH-1. seq_done on the wrap. dir forced down.
  - Ping-pong: move in dir. At step DEPTH-1 going up, flip dir and go to DEPTH-2. At 0 going down, flip dir, go to 1, and assert seq_done. Endpoints are never repeated.
  - Hold: step and dir frozen. Prescaler and tick keep running; no seq_done.
- Mode change mid-sequence: no reset of step. Entering ping-pong continues in the current dir.
- Table write: table[wr_addr] ← wr_data at the clock edge.
  - Writing the current step changes pattern_out the next cycle.
  - A write coinciding with a tick: the write is applied and the step advances in the same edge. pattern_out then shows table[new step] including any write to that index.
- Reset mid-operation restores every reset value asynchronously, including the table contents.

## Timing
- tick, seq_done and step are registered. seq_done is asserted in the cycle after the tick that caused the wrap, the same edge that updates step.
- pattern_out is valid the same cycle step changes; there is no extra latency.
- With DIV_BASE=2: div_sel=0 gives a period of 4 cycles, div_sel=3 gives 256.
- Forward and reverse: seq_done period = DEPTH ticks. Ping-pong: 2·(DEPTH−1) ticks.

## Structure
- Package pattern_seq_pkg holds:
  - the mode enum (MODE_FWD, MODE_REV, MODE_PING, MODE_HOLD);
  - the default-table function;
  - the prescale width constant (DIV_BASE+6).
- Sub-module tick_prescaler (parameter DIV_BASE): ports clk, reset, div_sel, tick. It contains the div_sel change detection.
- The top level holds the step/dir FSM, the table flops and half_rate.

## Test plan
- Reset, div_sel=0, mode=0, DEPTH=8: tick every 4 cycles. pattern_out reads 0x01, 0x02, …, 0x80, 0x01. seq_done at the 0x80→0x01 step, and half_rate toggles 0→1 there.
- mode=2 from step 0: step sequence 0,1,…,7,6,…,0,1. seq_done only at the 1→0→1 turnaround, i.e. once per 14 ticks.
- mode=1 from step 0: first tick gives step=7 and pattern_out=0x80 with seq_done. Then switch to mode=3: step stays 7 across ten ticks while tick keeps pulsing.
- Write table[3]=0xA5 while step=3: pattern_out=0xA5 the next cycle. A write to table[5] coincident with the tick moving to step 5 shows the new data immediately.
- div_sel changed 0→1 mid-period: no tick in the change cycle, next tick exactly 16 cycles later, then a 16-cycle period.
- Assert reset mid-sequence at step 6 after table writes: step=0 and pattern_out=0x01 immediately (asynchronous). Table is back to default; half_rate=0.

Source files
------------

// File: rtl/pattern_seq_pkg.sv
// Shared types and helpers for the pattern sequencer: step modes, direction,
// prescaler width and the power-on pattern table contents.
package pattern_seq_pkg;

  typedef enum logic [1:0] {
    MODE_FWD  = 2'd0,
    MODE_REV  = 2'd1,
    MODE_PING = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned PRESC_EXTRA = 6;

  function automatic int unsigned presc_width(int unsigned div_base);
    return div_base + PRESC_EXTRA;
  endfunction

  // Default table entry i is one-hot at bit (i mod width).
  function automatic int unsigned default_bit(int unsigned idx, int unsigned width);
    return idx % width;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: one-cycle tick every 2^(DIV_BASE+2*div_sel) cycles,
// restarting a full period whenever div_sel changes.
module tick_prescaler
  import pattern_seq_pkg::*;
#(
  parameter int unsigned DIV_BASE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] div_sel,
  output logic       tick
);

  localparam int unsigned CW = presc_width(DIV_BASE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] mask;
  logic [1:0]    dsel_q;
  logic          tick_q, tick_d;

  always_comb begin
    mask   = ~({CW{1'b1}} << (DIV_BASE + 2 * dsel_q));
    cnt_d  = cnt_q + 1'b1;
    tick_d = ((cnt_q & mask) == mask);
    // A select change restarts the period and swallows any tick due now.
    if (div_sel != dsel_q) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      dsel_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dsel_q <= div_sel;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Pattern sequencer top: step/direction FSM walking a writable pattern table,
// with sequence-done pulse and a half-rate toggle.
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DIV_BASE = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               div_sel,
  input  logic [1:0]               mode,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         pattern_out,
  output logic [$clog2(DEPTH)-1:0] step,
  output logic                     tick,
  output logic                     seq_done,
  output logic                     half_rate
);

  localparam int unsigned SW = $clog2(DEPTH);
  localparam logic [SW-1:0]    LAST  = SW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [SW-1:0]    step_q, step_d;
  dir_e             dir_q, dir_d;
  logic             done_q, done_d;
  logic             half_q, half_d;
  logic [WIDTH-1:0] tbl_q [DEPTH];
  logic             tick_w;

  tick_prescaler #(.DIV_BASE(DIV_BASE)) u_presc (
    .clk     (clk),
    .reset   (reset),
    .div_sel (div_sel),
    .tick    (tick_w)
  );

  always_comb begin
    step_d = step_q;
    dir_d  = dir_q;
    done_d = 1'b0;
    if (tick_w) begin
      case (mode_e'(mode))
        MODE_FWD: begin
          dir_d = DIR_UP;
          if (step_q == LAST) begin
            step_d = '0;
            done_d = 1'b1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        MODE_REV: begin
          dir_d = DIR_DOWN;
          if (step_q == '0) begin
            step_d = LAST;
            done_d = 1'b1;
          end else begin
            step_d = step_q - 1'b1;
          end
        end
        // Ping-pong bounces off both ends without repeating them; only the
        // bottom turnaround marks the end of a sequence.
        MODE_PING: begin
          if (dir_q == DIR_UP) begin
            if (step_q == LAST) begin
              dir_d  = DIR_DOWN;
              step_d = step_q - 1'b1;
            end else begin
              step_d = step_q + 1'b1;
            end
          end else begin
            if (step_q == '0) begin
              dir_d  = DIR_UP;
              step_d = SW'(1);
              done_d = 1'b1;
            end else begin
              step_d = step_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    half_d = half_q ^ done_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= '0;
      dir_q  <= DIR_UP;
      done_q <= 1'b0;
      half_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= ONE_W << default_bit(i, WIDTH);
      end
    end else begin
      step_q <= step_d;
      dir_q  <= dir_d;
      done_q <= done_d;
      half_q <= half_d;
      if (wr_en && (32'(wr_addr) < DEPTH)) begin
        tbl_q[wr_addr] <= wr_data;
      end
    end
  end

  assign pattern_out = tbl_q[step_q];
  assign step        = step_q;
  assign tick        = tick_w;
  assign seq_done    = done_q;
  assign half_rate   = half_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Randomized bench for pattern_sequencer against a cycle-level behavioural
// model of the stepping rules, plus directed checks of the key scenarios.
module tb_pattern_sequencer;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int DB = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   div_sel;
  logic [1:0]   mode;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [W-1:0] pattern_out;
  logic [2:0]   step;
  logic         tick;
  logic         seq_done;
  logic         half_rate;

  pattern_sequencer #(.WIDTH(W), .DEPTH(D), .DIV_BASE(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .div_sel     (div_sel),
    .mode        (mode),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pattern_out (pattern_out),
    .step        (step),
    .tick        (tick),
    .seq_done    (seq_done),
    .half_rate   (half_rate)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: cycle phase counter, step position, direction.
  int           m_cnt, m_dsel, m_tick, m_step, m_up, m_done, m_half;
  logic [W-1:0] m_tbl [D];

  task automatic model_reset();
    m_cnt = 0; m_dsel = 0; m_tick = 0; m_step = 0; m_up = 1; m_done = 0; m_half = 0;
    for (int i = 0; i < D; i++) m_tbl[i] = W'(1) << (i % W);
  endtask

  task automatic model_edge();
    int old_tick;
    if (reset) begin
      model_reset();
      return;
    end
    old_tick = m_tick;
    if (int'(div_sel) != m_dsel) begin
      m_dsel = int'(div_sel);
      m_cnt  = 0;
      m_tick = 0;
    end else begin
      m_tick = (((m_cnt + 1) % (1 << (DB + 2 * m_dsel))) == 0) ? 1 : 0;
      m_cnt  = (m_cnt + 1) % (1 << (DB + 6));
    end
    m_done = 0;
    if (old_tick == 1) begin
      case (mode)
        2'd0: begin m_up = 1; m_done = (m_step == D - 1) ? 1 : 0; m_step = (m_step + 1) % D; end
        2'd1: begin m_up = 0; m_done = (m_step == 0) ? 1 : 0; m_step = (m_step + D - 1) % D; end
        2'd2: begin
          if (m_up == 1) begin
            if (m_step == D - 1) begin m_up = 0; m_step = D - 2; end
            else m_step = m_step + 1;
          end else begin
            if (m_step == 0) begin m_up = 1; m_step = 1; m_done = 1; end
            else m_step = m_step - 1;
          end
        end
        default: ;
      endcase
    end
    if (m_done == 1) m_half = 1 - m_half;
    if (wr_en && int'(wr_addr) < D) m_tbl[wr_addr] = wr_data;
  endtask

  task automatic compare_all();
    check_eq("tick", 32'(tick), 32'(m_tick));
    check_eq("seq_done", 32'(seq_done), 32'(m_done));
    check_eq("half_rate", 32'(half_rate), 32'(m_half));
    check_eq("step", 32'(step), 32'(m_step));
    check_eq("pattern_out", 32'(pattern_out), 32'(m_tbl[m_step]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int seen;
    int n;
    reset = 1'b1; div_sel = 2'd0; mode = 2'd0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    repeat (3) cycle();
    check_eq("rst_pattern", 32'(pattern_out), 32'h01);
    reset = 1'b0;

    // Forward: wrap 0x80 -> 0x01 gives seq_done and half_rate rising.
    seen = 0;
    for (int i = 0; i < 60 && seen == 0; i++) begin
      cycle();
      if (seq_done) begin
        seen = 1;
        check_eq("fwd_wrap_pat", 32'(pattern_out), 32'h01);
        check_eq("fwd_wrap_half", 32'(half_rate), 32'h1);
      end
    end
    check_eq("fwd_done_seen", 32'(seen), 32'h1);

    // Ping-pong, then reverse and hold.
    mode = 2'd2;
    repeat (130) cycle();
    mode = 2'd1;
    repeat (30) cycle();
    mode = 2'd3;
    repeat (50) cycle();

    // Write the current step while no tick is pending.
    mode = 2'd0;
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      cycle();
      if (step == 3'd3 && !tick) seen = 1;
    end
    check_eq("wr_cur_reach", 32'(seen), 32'h1);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
    cycle();
    wr_en = 1'b0;
    check_eq("wr_cur_pat", 32'(pattern_out), 32'hA5);

    // Write coinciding with the tick that moves to step 5.
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      if (step == 3'd4 && tick) seen = 1;
      else cycle();
    end
    check_eq("wr_tick_reach", 32'(seen), 32'h1);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
    cycle();
    wr_en = 1'b0;
    check_eq("wr_tick_step", 32'(step), 32'd5);
    check_eq("wr_tick_pat", 32'(pattern_out), 32'h3C);

    // div_sel 0 -> 1 mid-period: next tick 16 edges after the change edge.
    mode = 2'd3;
    repeat (2) cycle();
    div_sel = 2'd1;
    cycle();
    check_eq("dsel_change_tick", 32'(tick), 32'h0);
    n = 0; seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      cycle();
      n++;
      if (tick) seen = 1;
    end
    check_eq("dsel_first_gap", 32'(n), 32'd16);
    n = 0; seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      cycle();
      n++;
      if (tick) seen = 1;
    end
    check_eq("dsel_period", 32'(n), 32'd16);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, D - 1));
      wr_data = W'($urandom);
      if ($urandom_range(0, 40) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 150) == 0) div_sel = 2'($urandom_range(0, 2));
      cycle();
    end
    wr_en = 1'b0;

    // Asynchronous reset mid-sequence at step 6 after table writes.
    mode = 2'd0; div_sel = 2'd0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
    cycle();
    wr_en = 1'b0;
    seen = 0;
    for (int i = 0; i < 600 && seen == 0; i++) begin
      cycle();
      if (step == 3'd6) seen = 1;
    end
    check_eq("rst_reach6", 32'(seen), 32'h1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_step", 32'(step), 32'd0);
    check_eq("arst_pat", 32'(pattern_out), 32'h01);
    check_eq("arst_half", 32'(half_rate), 32'h0);
    check_eq("arst_done", 32'(seq_done), 32'h0);
    model_reset();
    cycle();
    reset = 1'b0;
    repeat (80) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
